// File: rtl/conv1d_mac.sv
// Single-kernel 4-tap 1D convolution: one shared multiplier walks the taps,
// then the sum is biased, rescaled by FRAC, optionally ReLU-clamped and saturated.
module conv1d_mac #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int ACC_W = 40,
  parameter int RELU  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] w0,
  input  logic [W-1:0] w1,
  input  logic [W-1:0] w2,
  input  logic [W-1:0] w3,
  input  logic [W-1:0] bias,
  output logic         busy,
  output logic [W-1:0] out,
  output logic         out_valid,
  output logic         sat
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FINISH} state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]            r_x [4];
  logic [W-1:0]            r_w [4];
  logic [W-1:0]            r_bias;
  logic signed [ACC_W-1:0] r_acc;
  logic [1:0]              r_idx;
  logic [W-1:0]            r_out;
  logic                    r_vld;
  logic                    r_sat;

  logic signed [W-1:0]     w_xs;
  logic signed [W-1:0]     w_ws;
  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_biased;
  logic signed [ACC_W-1:0] w_scaled;
  logic signed [ACC_W-1:0] w_act;
  logic [W:0]              w_res;

  // Negative values become zero only when the ReLU variant is built.
  function automatic logic signed [ACC_W-1:0] apply_relu(input logic signed [ACC_W-1:0] s);
    if (RELU != 0 && s[ACC_W-1]) return '0;
    return s;
  endfunction

  // Returns {clipped, value}; the value fits iff all bits above the W-bit sign agree.
  function automatic logic [W:0] saturate(input logic signed [ACC_W-1:0] s);
    logic [ACC_W-W:0] top;
    top = s[ACC_W-1:W-1];
    if (&top || ~|top) return {1'b0, s[W-1:0]};
    if (s[ACC_W-1])    return {1'b1, 1'b1, {(W-1){1'b0}}};
    return {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  assign w_xs       = r_x[r_idx];
  assign w_ws       = r_w[r_idx];
  assign w_prod     = w_xs * w_ws;
  assign w_prod_ext = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-W){r_bias[W-1]}}, r_bias};
  assign w_biased   = r_acc + (w_bias_ext <<< FRAC);
  assign w_scaled   = w_biased >>> FRAC;
  assign w_act      = apply_relu(w_scaled);
  assign w_res      = saturate(w_act);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_MAC;
      S_MAC:    if (r_idx == 2'd3) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Operands are data only: captured at acceptance, never reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_x[0] <= x0;
      r_x[1] <= x1;
      r_x[2] <= x2;
      r_x[3] <= x3;
      r_w[0] <= w0;
      r_w[1] <= w1;
      r_w[2] <= w2;
      r_w[3] <= w3;
      r_bias <= bias;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_idx <= '0;
      r_out <= '0;
      r_vld <= 1'b0;
      r_sat <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_idx <= r_idx + 2'd1;
        end
        S_FINISH: begin
          r_out <= w_res[W-1:0];
          r_sat <= w_res[W];
          r_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_vld;
  assign sat       = r_sat;

endmodule

// File: tb/tb_conv1d_mac.sv
// Directed bench for conv1d_mac: a RELU=0 and a RELU=1 instance share the same stimulus.
module tb_conv1d_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x0, x1, x2, x3, w0, w1, w2, w3, bias;
  logic        busy0, vld0, sat0, busy1, vld1, sat1;
  logic [15:0] out0, out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv1d_mac #(.W(16), .FRAC(12), .ACC_W(40), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .bias(bias),
    .busy(busy0), .out(out0), .out_valid(vld0), .sat(sat0)
  );

  conv1d_mac #(.W(16), .FRAC(12), .ACC_W(40), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .bias(bias),
    .busy(busy1), .out(out1), .out_valid(vld1), .sat(sat1)
  );

  task automatic set_ops(input int a0, a1, a2, a3, c0, c1, c2, c3, b);
    x0 = 16'(a0); x1 = 16'(a1); x2 = 16'(a2); x3 = 16'(a3);
    w0 = 16'(c0); w1 = 16'(c1); w2 = 16'(c2); w3 = 16'(c3);
    bias = 16'(b);
  endtask

  // Leaves the bench at the falling edge just after the accepting edge k.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one operation on dut0 and checks the k+5 result, its one-cycle pulse and busy.
  task automatic run_one(input string name, input int exp_out, input logic exp_sat);
    logic signed [15:0] e;
    int early;
    e = 16'(exp_out);
    early = 0;
    pulse_start();
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", name, busy0); end
    repeat (4) begin
      @(negedge clk);
      if (vld0 !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL %s_early_valid got=%0d exp=0", name, early); end
    @(negedge clk);
    checks++;
    if (vld0 !== 1'b1) begin errors++; $display("FAIL %s_valid got=%b exp=1", name, vld0); end
    checks++;
    if (out0 !== e) begin errors++; $display("FAIL %s_out got=%0d exp=%0d", name, $signed(out0), e); end
    checks++;
    if (sat0 !== exp_sat) begin errors++; $display("FAIL %s_sat got=%b exp=%b", name, sat0, exp_sat); end
    @(negedge clk);
    checks++;
    if (vld0 !== 1'b0 || busy0 !== 1'b0 || out0 !== e) begin
      errors++;
      $display("FAIL %s_after got vld=%b busy=%b out=%0d exp vld=0 busy=0 out=%0d", name, vld0, busy0, $signed(out0), e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++;
    if (out0 !== 16'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", out0); end
    checks++;
    if (vld0 !== 1'b0 || sat0 !== 1'b0) begin errors++; $display("FAIL reset_flags got vld=%b sat=%b exp 0 0", vld0, sat0); end
    checks++;
    if (busy1 !== 1'b0 || out1 !== 16'd0) begin errors++; $display("FAIL reset_relu_inst got busy=%b out=%0d exp 0 0", busy1, out1); end
  endtask

  task automatic test_unity();
    set_ops(100, 200, 300, 400, 4096, 4096, 4096, 4096, 0);
    run_one("unity", 1000, 1'b0);
  endtask

  task automatic test_sat();
    set_ops(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 0);
    run_one("sat_pos", 32767, 1'b1);
    set_ops(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, 0);
    run_one("sat_neg", -32768, 1'b1);
  endtask

  task automatic test_bias_relu();
    set_ops(-1000, 0, 0, 0, 4096, 0, 0, 0, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    checks++;
    if (vld1 !== 1'b1 || out1 !== 16'd0 || sat1 !== 1'b0) begin
      errors++; $display("FAIL relu_clamp got vld=%b out=%0d sat=%b exp 1 0 0", vld1, $signed(out1), sat1);
    end
    checks++;
    if (out0 !== 16'(-1000)) begin errors++; $display("FAIL norelu_neg got=%0d exp=-1000", $signed(out0)); end
    @(negedge clk);
    set_ops(-1000, 0, 0, 0, 4096, 0, 0, 0, 1500);
    pulse_start();
    repeat (5) @(negedge clk);
    checks++;
    if (vld1 !== 1'b1 || out1 !== 16'd500) begin
      errors++; $display("FAIL relu_bias got vld=%b out=%0d exp 1 500", vld1, $signed(out1));
    end
    @(negedge clk);
  endtask

  task automatic test_rounding();
    set_ops(1, 0, 0, 0, 2048, 0, 0, 0, 0);
    run_one("round_pos", 0, 1'b0);
    set_ops(-1, 0, 0, 0, 2048, 0, 0, 0, 0);
    run_one("round_neg", -1, 1'b0);
  endtask

  task automatic test_protocol();
    int nvld;
    logic [15:0] last;
    set_ops(100, 200, 300, 400, 4096, 4096, 4096, 4096, 0);
    pulse_start();
    set_ops(1, 1, 1, 1, 4096, 4096, 4096, 4096, 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvld = 0; last = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vld0 === 1'b1) begin nvld++; last = out0; end
    end
    checks++;
    if (nvld != 1) begin errors++; $display("FAIL busy_ignore_count got=%0d exp=1", nvld); end
    checks++;
    if (last !== 16'd1000) begin errors++; $display("FAIL operand_capture got=%0d exp=1000", $signed(last)); end

    pulse_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || vld0 !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b vld=%b exp 0 0", busy0, vld0); end
    nvld = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (vld0 === 1'b1) nvld++;
    end
    checks++;
    if (nvld != 0 || out0 !== 16'd0 || sat0 !== 1'b0) begin
      errors++; $display("FAIL abort_no_result got nvld=%0d out=%0d sat=%b exp 0 0 0", nvld, $signed(out0), sat0);
    end
  endtask

  task automatic test_back_to_back();
    int nvld, prev, badgap, badval;
    set_ops(1, 2, 3, 4, 4096, 8192, -4096, 0, 5);
    nvld = 0; prev = -1; badgap = 0; badval = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (vld0 === 1'b1) begin
        nvld++;
        if (out0 !== 16'd7) badval++;
        if (prev < 0 ? (i != 5) : (i - prev != 6)) badgap++;
        prev = i;
      end
    end
    start = 1'b0;
    checks++;
    if (nvld != 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", nvld); end
    checks++;
    if (badgap != 0) begin errors++; $display("FAIL b2b_spacing got=%0d bad exp=0", badgap); end
    checks++;
    if (badval != 0) begin errors++; $display("FAIL b2b_value got=%0d bad exp=0", badval); end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unity();
    test_sat();
    test_bias_relu();
    test_rounding();
    test_protocol();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
